// File: rtl/addr_req_pkg.sv
// Shared types and helpers for the address-request queue.
// Every pointer in this block is at most 4 bits wide (DEPTH <= 16).
package addr_req_pkg;

    localparam int ADDR_W_DEFAULT = 32;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t address;
    } addr_req_t;

    // The last slot is DEPTH-1, which need not be a power of two,
    // so the wrap to 0 is an explicit compare.
    function automatic logic [3:0] ptr_wrap_inc(input logic [3:0] ptr, input int unsigned depth);
        if (32'(ptr) == depth - 32'd1) begin
            return 4'd0;
        end
        return ptr + 4'd1;
    endfunction

endpackage

// File: rtl/addr_req_queue_ram.sv
// Storage for the request queue: DEPTH x ADDR_W registers,
// one synchronous write port and one asynchronous read port.
module addr_req_queue_ram #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [ADDR_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [ADDR_W-1:0] rdata_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset. The valid flag comes from the pointers,
    // so stale contents are never presented as valid data.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/addr_req_queue.sv
// Decoupling FIFO between the address-request arbiter and its consumer.
// Optional checkers: define ADDR_REQ_QUEUE_ASSERT_EN.
module addr_req_queue
    import addr_req_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = 2,
    parameter int PIPE   = 0,
    parameter int FLOW   = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_enq_valid,
    input  logic [ADDR_W-1:0]          io_enq_bits_address,
    output logic                       io_enq_ready,
    input  logic                       io_deq_ready,
    output logic                       io_deq_valid,
    output logic [ADDR_W-1:0]          io_deq_bits_address,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam bit PIPE_EN = (PIPE != 0);
    localparam bit FLOW_EN = (FLOW != 0);

    logic [PTR_W-1:0]  enq_ptr_q, enq_ptr_d;
    logic [PTR_W-1:0]  deq_ptr_q, deq_ptr_d;
    logic              maybe_full_q, maybe_full_d;

    logic              ptr_match;
    logic              empty;
    logic              full;
    logic              do_enq;
    logic              do_deq;
    logic              bypass;
    logic              enq_fire;
    logic              deq_fire;
    logic [ADDR_W-1:0] ram_rdata;
    logic [CNT_W-1:0]  count;

    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign empty     = ptr_match & ~maybe_full_q;
    assign full      = ptr_match &  maybe_full_q;

    assign io_enq_ready = ~full | (PIPE_EN & io_deq_ready);
    assign io_deq_valid = ~empty | (FLOW_EN & io_enq_valid);

    assign do_enq = io_enq_valid & io_enq_ready;
    assign do_deq = io_deq_valid & io_deq_ready;

    // When empty in flow mode, a dequeue can only fire together with the
    // enqueue it passes through, so the storage is left untouched.
    assign bypass   = FLOW_EN & empty & do_deq;
    assign enq_fire = do_enq & ~bypass;
    assign deq_fire = do_deq & ~bypass;

    assign io_deq_bits_address = (FLOW_EN && empty) ? io_enq_bits_address : ram_rdata;

    addr_req_queue_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (enq_fire),
        .waddr_i (enq_ptr_q),
        .wdata_i (io_enq_bits_address),
        .raddr_i (deq_ptr_q),
        .rdata_o (ram_rdata)
    );

    // NOTE: every signal driven here takes a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (enq_fire) begin
            enq_ptr_d = PTR_W'(ptr_wrap_inc(4'(enq_ptr_q), DEPTH));
        end
        if (deq_fire) begin
            deq_ptr_d = PTR_W'(ptr_wrap_inc(4'(deq_ptr_q), DEPTH));
        end
        if (enq_fire != deq_fire) begin
            maybe_full_d = enq_fire;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    // Occupancy from registered state only; the wrapped case adds DEPTH back.
    always_comb begin
        count = '0;
        if (ptr_match) begin
            count = maybe_full_q ? CNT_W'(DEPTH) : '0;
        end else if (deq_ptr_q < enq_ptr_q) begin
            count = CNT_W'(enq_ptr_q) - CNT_W'(deq_ptr_q);
        end else begin
            count = CNT_W'(DEPTH) + CNT_W'(enq_ptr_q) - CNT_W'(deq_ptr_q);
        end
    end

    assign io_count = count;

`ifdef ADDR_REQ_QUEUE_ASSERT_EN
    a_no_enq_when_full: assert property (@(posedge clock) disable iff (!reset)
        (do_enq && full) |-> (PIPE_EN && do_deq));

    a_count_in_range: assert property (@(posedge clock) disable iff (!reset)
        io_count <= CNT_W'(DEPTH));

    a_enq_hold: assert property (@(posedge clock) disable iff (!reset)
        (io_enq_valid && !io_enq_ready) |=>
            (io_enq_valid && $stable(io_enq_bits_address)));

    a_deq_hold: assert property (@(posedge clock) disable iff (!reset)
        (io_deq_valid && !io_deq_ready) |=>
            (io_deq_valid && $stable(io_deq_bits_address)));
`else
    // Default build: no checkers, same ports and behaviour.
`endif

endmodule

// File: tb/tb_addr_req_queue.sv
// Directed bench for addr_req_queue: base, pipe, flow and depth-3 wrap
// instances, driven from a vector table plus hand-written sequences.
module tb_addr_req_queue;
    import addr_req_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // base: DEPTH=2 PIPE=0 FLOW=0
    logic b_ev, b_dr, b_er, b_dv;
    addr_t b_ea, b_da;
    logic [1:0] b_cnt;
    // pipe: DEPTH=2 PIPE=1
    logic p_ev, p_dr, p_er, p_dv;
    addr_t p_ea, p_da;
    logic [1:0] p_cnt;
    // flow: DEPTH=2 FLOW=1
    logic f_ev, f_dr, f_er, f_dv;
    addr_t f_ea, f_da;
    logic [1:0] f_cnt;
    // wrap: DEPTH=3
    logic w_ev, w_dr, w_er, w_dv;
    addr_t w_ea, w_da;
    logic [1:0] w_cnt;

    addr_req_queue #(.ADDR_W(32), .DEPTH(2), .PIPE(0), .FLOW(0)) u_base (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(b_ev), .io_enq_bits_address(b_ea), .io_enq_ready(b_er),
        .io_deq_ready(b_dr), .io_deq_valid(b_dv), .io_deq_bits_address(b_da),
        .io_count(b_cnt));

    addr_req_queue #(.ADDR_W(32), .DEPTH(2), .PIPE(1), .FLOW(0)) u_pipe (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(p_ev), .io_enq_bits_address(p_ea), .io_enq_ready(p_er),
        .io_deq_ready(p_dr), .io_deq_valid(p_dv), .io_deq_bits_address(p_da),
        .io_count(p_cnt));

    addr_req_queue #(.ADDR_W(32), .DEPTH(2), .PIPE(0), .FLOW(1)) u_flow (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(f_ev), .io_enq_bits_address(f_ea), .io_enq_ready(f_er),
        .io_deq_ready(f_dr), .io_deq_valid(f_dv), .io_deq_bits_address(f_da),
        .io_count(f_cnt));

    addr_req_queue #(.ADDR_W(32), .DEPTH(3), .PIPE(0), .FLOW(0)) u_wrap (
        .clock(clk), .reset(rst_n),
        .io_enq_valid(w_ev), .io_enq_bits_address(w_ea), .io_enq_ready(w_er),
        .io_deq_ready(w_dr), .io_deq_valid(w_dv), .io_deq_bits_address(w_da),
        .io_count(w_cnt));

    typedef struct {
        logic       ev;
        addr_t      ea;
        logic       dr;
        logic       er;
        logic       dv;
        addr_t      da;
        logic [1:0] cnt;
    } vec_t;

    localparam int N_VEC = 14;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcvd;
        int cyc;

        //            ev    ea            dr    er    dv    da            cnt
        vecs[0]  = '{1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0,       2'd0};
        vecs[1]  = '{1'b1, 32'h1000,    1'b0, 1'b1, 1'b0, 32'h0,       2'd0};
        vecs[2]  = '{1'b1, 32'h2000,    1'b0, 1'b1, 1'b1, 32'h1000,    2'd1};
        vecs[3]  = '{1'b1, 32'h3000,    1'b0, 1'b0, 1'b1, 32'h1000,    2'd2};
        vecs[4]  = '{1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h1000,    2'd2};
        vecs[5]  = '{1'b0, 32'h0,       1'b1, 1'b1, 1'b1, 32'h2000,    2'd1};
        vecs[6]  = '{1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 32'h0,       2'd0};
        vecs[7]  = '{1'b1, 32'h4000,    1'b1, 1'b1, 1'b0, 32'h0,       2'd0};
        vecs[8]  = '{1'b1, 32'h5000,    1'b1, 1'b1, 1'b1, 32'h4000,    2'd1};
        vecs[9]  = '{1'b1, 32'h6000,    1'b0, 1'b1, 1'b1, 32'h5000,    2'd1};
        vecs[10] = '{1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h5000,    2'd2};
        vecs[11] = '{1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h5000,    2'd2};
        vecs[12] = '{1'b0, 32'h0,       1'b1, 1'b1, 1'b1, 32'h6000,    2'd1};
        vecs[13] = '{1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0,       2'd0};

        b_ev = 1'b0; b_ea = '0; b_dr = 1'b0;
        p_ev = 1'b0; p_ea = '0; p_dr = 1'b0;
        f_ev = 1'b0; f_ea = '0; f_dr = 1'b0;
        w_ev = 1'b0; w_ea = '0; w_dr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.base.enq_ready", 32'(b_er), 32'd1);
        check("reset.base.deq_valid", 32'(b_dv), 32'd0);
        check("reset.base.count", 32'(b_cnt), 32'd0);
        check("reset.flow.deq_valid", 32'(f_dv), 32'd0);
        check("reset.wrap.count", 32'(w_cnt), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Table: fill/drain, full backpressure, simultaneous enq+deq, wrap
        for (int i = 0; i < N_VEC; i++) begin
            b_ev = vecs[i].ev;
            b_ea = vecs[i].ea;
            b_dr = vecs[i].dr;
            @(negedge clk);
            check($sformatf("base[%0d].enq_ready", i), 32'(b_er), 32'(vecs[i].er));
            check($sformatf("base[%0d].deq_valid", i), 32'(b_dv), 32'(vecs[i].dv));
            check($sformatf("base[%0d].count", i), 32'(b_cnt), 32'(vecs[i].cnt));
            if (vecs[i].dv) begin
                check($sformatf("base[%0d].deq_addr", i), b_da, vecs[i].da);
            end
            next_cycle();
        end
        b_ev = 1'b0; b_dr = 1'b0;

        // Backpressure stability: head 0x1234 held for 5 cycles
        b_ev = 1'b1; b_ea = 32'h1234;
        next_cycle();
        b_ev = 1'b0; b_ea = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold[%0d].deq_valid", k), 32'(b_dv), 32'd1);
            check($sformatf("hold[%0d].deq_addr", k), b_da, 32'h1234);
            next_cycle();
        end
        b_dr = 1'b1;
        @(negedge clk);
        check("hold.release.deq_addr", b_da, 32'h1234);
        next_cycle();
        @(negedge clk);
        check("hold.after.deq_valid", 32'(b_dv), 32'd0);
        next_cycle();
        b_dr = 1'b0;

        // PIPE=1: full with A0,B0, enqueue C0 while dequeuing
        p_ev = 1'b1; p_ea = 32'hA0;
        next_cycle();
        p_ea = 32'hB0;
        next_cycle();
        p_ea = 32'hC0;
        @(negedge clk);
        check("pipe.full_noready.enq_ready", 32'(p_er), 32'd0);
        check("pipe.full_noready.count", 32'(p_cnt), 32'd2);
        next_cycle();
        p_dr = 1'b1;
        @(negedge clk);
        check("pipe.full_deq.enq_ready", 32'(p_er), 32'd1);
        check("pipe.full_deq.deq_valid", 32'(p_dv), 32'd1);
        check("pipe.full_deq.deq_addr", p_da, 32'hA0);
        check("pipe.full_deq.count", 32'(p_cnt), 32'd2);
        next_cycle();
        p_ev = 1'b0; p_ea = 32'h0;
        @(negedge clk);
        check("pipe.second.deq_addr", p_da, 32'hB0);
        check("pipe.second.count", 32'(p_cnt), 32'd2);
        next_cycle();
        @(negedge clk);
        check("pipe.third.deq_addr", p_da, 32'hC0);
        check("pipe.third.count", 32'(p_cnt), 32'd1);
        next_cycle();
        @(negedge clk);
        check("pipe.empty.deq_valid", 32'(p_dv), 32'd0);
        check("pipe.empty.count", 32'(p_cnt), 32'd0);
        p_dr = 1'b0;
        next_cycle();

        // FLOW=1: zero-latency pass-through, then a buffered flow entry
        f_dr = 1'b1;
        @(negedge clk);
        check("flow.idle.deq_valid", 32'(f_dv), 32'd0);
        next_cycle();
        f_ev = 1'b1; f_ea = 32'hDEAD_BEEF;
        @(negedge clk);
        check("flow.pass.deq_valid", 32'(f_dv), 32'd1);
        check("flow.pass.deq_addr", f_da, 32'hDEAD_BEEF);
        check("flow.pass.enq_ready", 32'(f_er), 32'd1);
        check("flow.pass.count", 32'(f_cnt), 32'd0);
        next_cycle();
        f_ev = 1'b0; f_ea = 32'h0;
        @(negedge clk);
        check("flow.after.deq_valid", 32'(f_dv), 32'd0);
        check("flow.after.count", 32'(f_cnt), 32'd0);
        next_cycle();
        f_ev = 1'b1; f_ea = 32'h77; f_dr = 1'b0;
        @(negedge clk);
        check("flow.stall.deq_valid", 32'(f_dv), 32'd1);
        check("flow.stall.deq_addr", f_da, 32'h77);
        next_cycle();
        f_ev = 1'b0; f_ea = 32'h0;
        @(negedge clk);
        check("flow.stored.deq_addr", f_da, 32'h77);
        check("flow.stored.count", 32'(f_cnt), 32'd1);
        next_cycle();
        f_dr = 1'b1;
        next_cycle();
        @(negedge clk);
        check("flow.drained.deq_valid", 32'(f_dv), 32'd0);
        f_dr = 1'b0;
        next_cycle();

        // DEPTH=3 wrap: stream 0..9 with deq_ready toggling 1,0,1,0
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 10 && cyc < 100) begin
            w_ev = (sent < 10);
            w_ea = 32'(sent);
            w_dr = (cyc % 2 == 0);
            @(negedge clk);
            check("wrap.count", 32'(w_cnt), 32'(sent - rcvd));
            check("wrap.deq_valid", 32'(w_dv), 32'(sent != rcvd));
            if (w_dv && w_dr) begin
                check("wrap.order", w_da, 32'(rcvd));
                rcvd++;
            end
            if (w_ev && w_er) begin
                sent++;
            end
            next_cycle();
            cyc++;
        end
        check("wrap.all_received", 32'(rcvd), 32'd10);
        w_ev = 1'b0; w_dr = 1'b0;

        // Asynchronous reset between edges with two entries held
        b_ev = 1'b1; b_ea = 32'h11;
        next_cycle();
        b_ea = 32'h22;
        next_cycle();
        b_ev = 1'b0; b_ea = 32'h0;
        @(negedge clk);
        check("areset.before.count", 32'(b_cnt), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.deq_valid", 32'(b_dv), 32'd0);
        check("areset.count", 32'(b_cnt), 32'd0);
        check("areset.enq_ready", 32'(b_er), 32'd1);
        #1;
        rst_n = 1'b1;
        b_ev = 1'b1; b_ea = 32'h55;
        @(negedge clk);
        check("areset.enq.deq_valid", 32'(b_dv), 32'd0);
        next_cycle();
        b_ev = 1'b0; b_ea = 32'h0;
        @(negedge clk);
        check("areset.next.deq_valid", 32'(b_dv), 32'd1);
        check("areset.next.deq_addr", b_da, 32'h55);
        check("areset.next.count", 32'(b_cnt), 32'd1);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
